// File: rtl/wrap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wrap_ctrl_pkg
//  Purpose  : Shared types and constants for the boundary wrapper chain
//             sequencer: FSM state encoding, mode encodings and the default
//             wrapper chain geometry.
//  Revision : 1.0  initial release
// ============================================================================
package wrap_ctrl_pkg;

    // Sequencer states; the encoding width is fixed so the state register
    // is exactly three flops.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SHIFT   = 3'd2,
        UPDATE  = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Mode encodings: bit0 operates the input cells, bit1 the output cells.
    localparam logic [1:0] MODE_ILLEGAL = 2'b00;
    localparam logic [1:0] MODE_IN      = 2'b01;
    localparam logic [1:0] MODE_OUT     = 2'b10;
    localparam logic [1:0] MODE_BOTH    = 2'b11;

    // Default chain geometry: input cells sit at the head of the chain.
    localparam int DEF_IN_LEN  = 3;
    localparam int DEF_OUT_LEN = 3;

endpackage : wrap_ctrl_pkg
`default_nettype wire

// File: rtl/wrap_chain_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : wrap_chain_ctrl_if
//  Purpose  : Bundles the request/response handshake, the serial scan path
//             and the wrapper control strobes between the test-control side
//             and the wrapper chain sequencer.
//  Modports : master - test-control logic and wrapper chain (drives start,
//                      mode, wdata, sel_release, scan_so)
//             slave  - wrap_chain_ctrl sequencer
//  Signals  : start, mode[1:0], wdata[CHAIN_LEN], sel_release (request side)
//             busy, done, err, rdata[CHAIN_LEN]              (response side)
//             scan_si, scan_so                                (serial path)
//             TDR_CAPTURE/SHIFT/UPDATE, *_TDR_EN, *_sel       (wrapper ctrl)
//  Revision : 1.0  initial release
// ============================================================================
interface wrap_chain_ctrl_if #(
    parameter int IN_LEN  = wrap_ctrl_pkg::DEF_IN_LEN,
    parameter int OUT_LEN = wrap_ctrl_pkg::DEF_OUT_LEN
);
    localparam int CHAIN_LEN = IN_LEN + OUT_LEN;

    // Request side
    logic                 start;
    logic [1:0]           mode;
    logic [CHAIN_LEN-1:0] wdata;
    logic                 sel_release;   // drops both selects back to functional

    // Response side
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [CHAIN_LEN-1:0] rdata;

    // Serial path: scan_si feeds CTII, scan_so comes back from CTOO
    logic                 scan_si;
    logic                 scan_so;

    // Wrapper control
    logic                 TDR_CAPTURE;
    logic                 TDR_SHIFT;
    logic                 TDR_UPDATE;
    logic                 INSCANWRAP_TDR_EN;
    logic                 OUTSCANWRAP_TDR_EN;
    logic                 inscanwrap_sel;
    logic                 outscanwrap_sel;

    modport master (
        output start, mode, wdata, sel_release, scan_so,
        input  busy, done, err, rdata, scan_si,
        input  TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE,
        input  INSCANWRAP_TDR_EN, OUTSCANWRAP_TDR_EN,
        input  inscanwrap_sel, outscanwrap_sel
    );

    modport slave (
        input  start, mode, wdata, sel_release, scan_so,
        output busy, done, err, rdata, scan_si,
        output TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE,
        output INSCANWRAP_TDR_EN, OUTSCANWRAP_TDR_EN,
        output inscanwrap_sel, outscanwrap_sel
    );

endinterface : wrap_chain_ctrl_if
`default_nettype wire

// File: rtl/wrap_shift_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : wrap_shift_cnt
//  Purpose  : Loadable down-counter that times the shift phase. load_i
//             presets it to CHAIN_LEN-1; each enabled cycle counts down by
//             one; last_o flags the final shift cycle (count == 0).
//  Ports    : clk      in   clock, rising edge
//             rst_n    in   asynchronous active-low reset
//             load_i   in   preset to CHAIN_LEN-1
//             en_i     in   count down (one real shift happened)
//             last_o   out  current cycle is the last shift
//  Revision : 1.0  initial release
// ============================================================================
module wrap_shift_cnt #(
    parameter  int CHAIN_LEN = 6,
    localparam int W         = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(CHAIN_LEN - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == '0);

endmodule : wrap_shift_cnt
`default_nettype wire

// File: rtl/wrap_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wrap_chain_ctrl
//  Purpose  : Sequencer for the boundary wrapper chain (IN_LEN input cells
//             followed by OUT_LEN output cells). On a legal start it runs
//             CAPTURE -> SHIFT (CHAIN_LEN cycles) -> UPDATE -> DONE, shifting
//             wdata in LSB first while collecting the captured chain contents,
//             then sets the wrapper test-data selects for the operated cells.
//  Ports    : TDR_TCK      in   clock, all state on rising edge
//             TDR_TRESETN  in   asynchronous active-low reset
//             pause_i      in   freeze shifting (only with the macro below)
//             bus          slave modport of wrap_chain_ctrl_if
//  Options  : WRAP_CHAIN_CTRL_PAUSE_EN adds pause_i; pause during SHIFT
//             holds the shift (TDR_SHIFT low, counter frozen, no sampling).
//  Revision : 1.0  initial release
// ============================================================================
module wrap_chain_ctrl
    import wrap_ctrl_pkg::*;
#(
    parameter int IN_LEN  = DEF_IN_LEN,
    parameter int OUT_LEN = DEF_OUT_LEN
) (
    input  logic              TDR_TCK,
    input  logic              TDR_TRESETN,
`ifdef WRAP_CHAIN_CTRL_PAUSE_EN
    input  logic              pause_i,
`endif
    wrap_chain_ctrl_if.slave  bus
);

    localparam int CHAIN_LEN = IN_LEN + OUT_LEN;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t               state_q,   state_d;
    logic [1:0]           mode_q,    mode_d;
    logic [CHAIN_LEN-1:0] wsr_q,     wsr_d;     // remaining bits to send, LSB next
    logic [CHAIN_LEN-1:0] rsr_q,     rsr_d;     // sampled scan_so, fills from MSB
    logic [CHAIN_LEN-1:0] rdata_q,   rdata_d;
    logic                 scan_si_q, scan_si_d;

    // Registered output strobes
    logic cap_q,    cap_d;
    logic shift_q,  shift_d;
    logic upd_q,    upd_d;
    logic busy_q,   busy_d;
    logic done_q,   done_d;
    logic err_q,    err_d;
    logic en_in_q,  en_in_d;
    logic en_out_q, en_out_d;
    logic sel_in_q, sel_in_d;
    logic sel_out_q, sel_out_d;

    logic cnt_load;
    logic cnt_last;
    logic pause_act;
    logic en_window;

`ifdef WRAP_CHAIN_CTRL_PAUSE_EN
    // Only honoured once already shifting; a pause seen while entering
    // SHIFT from CAPTURE is ignored.
    assign pause_act = pause_i && (state_q == SHIFT);
`else
    assign pause_act = 1'b0;
`endif

    // Counter advances only on edges that close a real shift cycle, so a
    // paused cycle never consumes a count.
    wrap_shift_cnt #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_shift_cnt (
        .clk    (TDR_TCK),
        .rst_n  (TDR_TRESETN),
        .load_i (cnt_load),
        .en_i   (shift_q),
        .last_o (cnt_last)
    );

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        wsr_d     = wsr_q;
        rsr_d     = rsr_q;
        rdata_d   = rdata_q;
        scan_si_d = scan_si_q;
        sel_in_d  = sel_in_q;
        sel_out_d = sel_out_q;
        err_d     = 1'b0;
        cnt_load  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.sel_release) begin
                    sel_in_d  = 1'b0;
                    sel_out_d = 1'b0;
                end
                if (bus.start) begin
                    if (bus.mode == MODE_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = CAPTURE;
                        mode_d  = bus.mode;
                        wsr_d   = bus.wdata;
                    end
                end
            end

            CAPTURE: begin
                // Present the first data bit for the first shift cycle.
                state_d   = SHIFT;
                cnt_load  = 1'b1;
                scan_si_d = wsr_q[0];
                wsr_d     = wsr_q >> 1;
            end

            SHIFT: begin
                // shift_q marks a real shift cycle: the cells move on this
                // edge, so scan_so is sampled here as well.
                if (shift_q) begin
                    rsr_d = {bus.scan_so, rsr_q[CHAIN_LEN-1:1]};
                    if (cnt_last) begin
                        state_d   = UPDATE;
                        scan_si_d = 1'b0;
                    end else begin
                        scan_si_d = wsr_q[0];
                        wsr_d     = wsr_q >> 1;
                    end
                end
            end

            UPDATE: begin
                // Sampled data is complete; present it together with done.
                state_d = DONE;
                rdata_d = rsr_q;
                if ((mode_q & MODE_IN) != 2'b00) begin
                    sel_in_d = 1'b1;
                end
                if ((mode_q & MODE_OUT) != 2'b00) begin
                    sel_out_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they come straight
        // out of flops and stay mutually exclusive.
        cap_d     = (state_d == CAPTURE);
        shift_d   = (state_d == SHIFT) && !pause_act;
        upd_d     = (state_d == UPDATE);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        en_window = (state_d == CAPTURE) || (state_d == SHIFT) || (state_d == UPDATE);
        en_in_d   = en_window && ((mode_d & MODE_IN)  != 2'b00);
        en_out_d  = en_window && ((mode_d & MODE_OUT) != 2'b00);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge TDR_TCK or negedge TDR_TRESETN) begin
        if (!TDR_TRESETN) begin
            state_q   <= IDLE;
            mode_q    <= 2'b00;
            wsr_q     <= '0;
            rsr_q     <= '0;
            rdata_q   <= '0;
            scan_si_q <= 1'b0;
            cap_q     <= 1'b0;
            shift_q   <= 1'b0;
            upd_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            en_in_q   <= 1'b0;
            en_out_q  <= 1'b0;
            sel_in_q  <= 1'b0;
            sel_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            wsr_q     <= wsr_d;
            rsr_q     <= rsr_d;
            rdata_q   <= rdata_d;
            scan_si_q <= scan_si_d;
            cap_q     <= cap_d;
            shift_q   <= shift_d;
            upd_q     <= upd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            en_in_q   <= en_in_d;
            en_out_q  <= en_out_d;
            sel_in_q  <= sel_in_d;
            sel_out_q <= sel_out_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy               = busy_q;
    assign bus.done               = done_q;
    assign bus.err                = err_q;
    assign bus.rdata              = rdata_q;
    assign bus.scan_si            = scan_si_q;
    assign bus.TDR_CAPTURE        = cap_q;
    assign bus.TDR_SHIFT          = shift_q;
    assign bus.TDR_UPDATE         = upd_q;
    assign bus.INSCANWRAP_TDR_EN  = en_in_q;
    assign bus.OUTSCANWRAP_TDR_EN = en_out_q;
    assign bus.inscanwrap_sel     = sel_in_q;
    assign bus.outscanwrap_sel    = sel_out_q;

endmodule : wrap_chain_ctrl
`default_nettype wire
